maxpool2_stream: RTL and testbench
==================================

# maxpool2_stream

Streaming 2x2, stride-2 max-pool stage between the conv1 activation output and the conv2 line buffer. It consumes a raster-order stream of 26x26 unsigned 8-bit activations and emits the 13x13 pooled stream in raster order, one pixel per valid strobe. That output stream is the direct `valid_in`/`pixel_in` feed of `conv2_buf`. The block has no backpressure: it stores one half-row of partial maxima and a single horizontal hold register.

## Interface

- `WIDTH`, 26: input frame width in pixels.
- `HEIGHT`, 26: input frame height in pixels.
- `DATA_W`, 8: pixel width; values are unsigned.

- `clk`  input  1  rising-edge clock; the block uses one clock.
- `rst`  input  1  asynchronous, active-high reset.
- `valid_in`  input  1  `pixel_in` is valid this cycle.
- `pixel_in`  input  DATA_W  input activation, raster order.
- `pixel_out`  output  DATA_W  pooled pixel, registered.
- `valid_out`  output  1  one-cycle strobe; `pixel_out` is valid.
- `frame_end`  output  1  one-cycle strobe, coincident with the last `valid_out` of a frame.

## Operation

- **Counters.** `col` runs 0..WIDTH-1 and `row` runs 0..HEIGHT-1.
  - They advance only on cycles with `valid_in`=1.
  - `col` wraps to 0 and increments `row`.
  - After (HEIGHT-1, WIDTH-1), both counters wrap to 0, so the next frame follows with no gap.
- **Even col (any row).** Latch `pixel_in` into `hold`.
- **Odd col, even row.** Write `max(hold, pixel_in)` to `rowbuf[col>>1]`. `rowbuf` has WIDTH/2 entries.
- **Odd col, odd row.**
  - Register `max(hold, pixel_in, rowbuf[col>>1])` into `pixel_out`.
  - Assert `valid_out` for one cycle.
  - Also assert `frame_end` if this is the last output of the frame, i.e. row = 2*(HEIGHT/2)-1 and col = 2*(WIDTH/2)-1.
- **Odd dimensions.** If WIDTH or HEIGHT is odd, the trailing column or row still advances the counters but produces nothing and writes nothing. Output size is floor(W/2) x floor(H/2).
- **Comparisons.** All comparisons are unsigned, DATA_W wide. Ties pass the equal value; no widening is needed.
- **Output rate.** Each frame produces (WIDTH/2)*(HEIGHT/2) outputs, which is 169 at the defaults. No outputs occur during even input rows.
- **`rowbuf` reset.** `rowbuf` needs no reset; every entry is written in an even row before it is read in the following odd row.

## Timing

- **Reset values.** `pixel_out`=0, `valid_out`=0, `frame_end`=0, `col`=0, `row`=0, `hold`=0.
  - Reset takes effect immediately (asynchronous), including in the middle of a frame.
  - The first `valid_in` after reset deassertion is pixel (0,0).
- **Latency.** `valid_out` and `pixel_out` appear one clock after the rising edge that samples the bottom-right pixel of the 2x2 window.
- **`valid_out` and `frame_end` width.** Both are high for exactly one cycle per event. They are 0 on every cycle not following a qualifying odd/odd input.
- **`pixel_out` hold.** `pixel_out` holds its last value while `valid_out`=0.
- **Gaps in `valid_in`.** Gaps of any length freeze the counters, `hold` and `rowbuf`. Gaps change only the timing of outputs, never their values.
- **Throughput.** The block accepts one input per cycle. It emits at most one output per two consecutive inputs, which the downstream `conv2_buf` accepts unconditionally.
- **Frame boundary.** The final input of frame N and the first input of frame N+1 may arrive on consecutive cycles. The `valid_out`/`frame_end` of frame N is then unaffected.

## Test plan

- **Ramp.** Stimulus: pixel(r,c) = r+c, with `valid_in` continuous.
  - Required: exactly 169 `valid_out` pulses, out(i,j) = 2i+2j+2, so the first output is 2 and the last is 50.
  - Required: `frame_end` high only with the 169th pulse.
- **Descending.** Stimulus: pixel(r,c) = 255-(r+c).
  - Required: out(i,j) = 255-2i-2j, so the first output is 255 and the last is 207. This confirms the max is independent of its position in the window.
- **Single spike.** Stimulus: all pixels 0 except pixel(5,7)=255.
  - Required: out(2,3) = 255, i.e. the 30th output; all other 168 outputs are 0.
- **Bubbles.** Stimulus: the ramp stimulus with `valid_in` toggling 1/0 every cycle, plus random gaps of up to 5 cycles.
  - Required: an output sequence identical to the ramp test, 169 pulses, and no `valid_out` in the cycle after any `valid_in`=0 cycle.
- **Back-to-back frames.** Stimulus: two ramp frames sent contiguously.
  - Required: 338 outputs and two `frame_end` pulses.
  - Required: frame 2 values equal frame 1, with no stale `rowbuf` or `hold` contamination.
- **Mid-frame reset.** Stimulus: assert `rst` for 2 cycles after 100 input pixels.
  - Required: `valid_out`, `pixel_out` and `frame_end` go to 0 asynchronously.
  - Required: a following full ramp frame yields the exact ramp output sequence starting at 2.

Source files
------------

// File: rtl/maxpool2_stream.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2_stream
// Purpose  : Streaming 2x2, stride-2 max-pool. Consumes a raster-order
//            WIDTH x HEIGHT stream of unsigned pixels and emits the
//            floor(W/2) x floor(H/2) pooled stream in raster order.
//            Stores one half-row of partial (horizontal) maxima plus a
//            single horizontal hold register. No backpressure.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-high reset
//            valid_in   - pixel_in valid this cycle
//            pixel_in   - input activation (raster order)
//            pixel_out  - pooled pixel (registered, holds between strobes)
//            valid_out  - one-cycle strobe, pixel_out valid
//            frame_end  - one-cycle strobe with the last valid_out of frame
// Revision : 1.0  initial release
// ============================================================================
module maxpool2_stream #(
  parameter int WIDTH  = 26,
  parameter int HEIGHT = 26,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pixel_in,
  output logic [DATA_W-1:0] pixel_out,
  output logic              valid_out,
  output logic              frame_end
);

  localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int HALF_W = WIDTH / 2;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [COL_W-1:0] c_col_last     = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] c_row_last     = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] c_col_lastpair = COL_W'(2 * (WIDTH / 2) - 1);
  localparam logic [ROW_W-1:0] c_row_lastpair = ROW_W'(2 * (HEIGHT / 2) - 1);
  localparam bit               c_w_odd        = (WIDTH  % 2) == 1;
  localparam bit               c_h_odd        = (HEIGHT % 2) == 1;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_rowbuf [0:HALF_W-1];

  logic              w_col_wrap;
  logic              w_col_in;     // column belongs to a complete 2-wide pair
  logic              w_row_in;     // row belongs to a complete 2-high pair
  logic              w_hold_en;
  logic              w_wr_rowbuf;
  logic              w_emit;
  logic              w_last_out;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_max2;
  logic [DATA_W-1:0] w_max3;

  assign w_col_wrap  = (r_col == c_col_last);
  // The trailing column/row of an odd dimension is always the even index
  // WIDTH-1 / HEIGHT-1; it still advances the counters but has no effect.
  assign w_col_in    = !(c_w_odd && (r_col == c_col_last));
  assign w_row_in    = !(c_h_odd && (r_row == c_row_last));

  assign w_hold_en   = valid_in && !r_col[0] && w_col_in && w_row_in;
  assign w_wr_rowbuf = valid_in &&  r_col[0] && !r_row[0] && w_row_in;
  assign w_emit      = valid_in &&  r_col[0] &&  r_row[0];
  assign w_last_out  = (r_row == c_row_lastpair) && (r_col == c_col_lastpair);

  assign w_idx  = IDX_W'(r_col >> 1);
  assign w_rb   = r_rowbuf[w_idx];
  assign w_max2 = (r_hold > pixel_in) ? r_hold : pixel_in;
  assign w_max3 = (w_max2 > w_rb)     ? w_max2 : w_rb;

  // Counters, hold register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hold    <= '0;
      pixel_out <= '0;
      valid_out <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      frame_end <= 1'b0;

      if (valid_in) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_hold_en) begin
        r_hold <= pixel_in;
      end

      if (w_emit) begin
        pixel_out <= w_max3;
        valid_out <= 1'b1;
        frame_end <= w_last_out;
      end
    end
  end

  // Half-row of horizontal maxima. Every entry is written in an even row
  // before it is read in the following odd row, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_wr_rowbuf) begin
      r_rowbuf[w_idx] <= w_max2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool2_stream
// Purpose  : Self-checking bench for maxpool2_stream with directed frames
//            (ramp, descending, single spike, bubbles, back-to-back frames,
//            mid-frame reset) and hand-derived expected pooled values.
// Revision : 1.0  initial release
// ============================================================================
module tb_maxpool2_stream;

  localparam int W      = 26;
  localparam int H      = 26;
  localparam int OW     = W / 2;
  localparam int NOUT   = (W / 2) * (H / 2);

  localparam int c_mode_ramp  = 0;
  localparam int c_mode_desc  = 1;
  localparam int c_mode_spike = 2;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] pixel_in;
  logic [7:0] pixel_out;
  logic       valid_out;
  logic       frame_end;

  int checks;
  int failures;
  int stray_fe;
  int bubble_viol;
  logic last_vin;

  logic [7:0] q_px[$];
  logic       q_fe[$];

  maxpool2_stream #(
    .WIDTH  (W),
    .HEIGHT (H),
    .DATA_W (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .pixel_in  (pixel_in),
    .pixel_out (pixel_out),
    .valid_out (valid_out),
    .frame_end (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // valid_in as sampled by the most recent rising edge.
  always @(posedge clk) last_vin = valid_in;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_out) begin
      q_px.push_back(pixel_out);
      q_fe.push_back(frame_end);
      if (!last_vin) bubble_viol++;
    end
    if (frame_end && !valid_out) stray_fe++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] px);
    @(posedge clk);
    #1;
    valid_in = v;
    pixel_in = px;
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    case (mode)
      c_mode_ramp: return 8'(r + c);
      c_mode_desc: return 8'(255 - (r + c));
      default:     return (r == 5 && c == 7) ? 8'd255 : 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_out(input int mode, input int i, input int j);
    case (mode)
      c_mode_ramp: return 8'(2 * i + 2 * j + 2);
      c_mode_desc: return 8'(255 - 2 * i - 2 * j);
      default:     return (i == 2 && j == 3) ? 8'd255 : 8'd0;
    endcase
  endfunction

  // Sends one frame; with bubbles each pixel is followed by a 1-cycle gap
  // plus 0..5 extra idle cycles.
  task automatic send_frame(input int mode, input bit bubbles);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, pix(mode, r, c));
        if (bubbles) begin
          drive(1'b0, 8'd0);
          repeat ($urandom_range(0, 5)) drive(1'b0, 8'd0);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0);
  endtask

  task automatic check_frames(input string tag, input int mode, input int nframes);
    int n;
    chk($sformatf("%s_count", tag), q_px.size(), nframes * NOUT);
    n = (q_px.size() < nframes * NOUT) ? q_px.size() : nframes * NOUT;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = k % NOUT;
      chk($sformatf("%s_px[%0d]", tag, k), q_px[k], exp_out(mode, idx / OW, idx % OW));
      chk($sformatf("%s_fe[%0d]", tag, k), q_fe[k], (idx == NOUT - 1) ? 1 : 0);
    end
    q_px.delete();
    q_fe.delete();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    stray_fe    = 0;
    bubble_viol = 0;
    last_vin    = 1'b0;
    rst         = 1'b1;
    valid_in    = 1'b0;
    pixel_in    = 8'd0;

    // Reset state, observed before any clock edge.
    #1;
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_frame_end", frame_end, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Ramp.
    send_frame(c_mode_ramp, 1'b0);
    idle(4);
    check_frames("ramp", c_mode_ramp, 1);

    // Descending.
    send_frame(c_mode_desc, 1'b0);
    idle(4);
    check_frames("desc", c_mode_desc, 1);

    // Single spike.
    send_frame(c_mode_spike, 1'b0);
    idle(4);
    check_frames("spike", c_mode_spike, 1);

    // Bubbles.
    bubble_viol = 0;
    send_frame(c_mode_ramp, 1'b1);
    idle(4);
    check_frames("bubble", c_mode_ramp, 1);
    chk("bubble_viol", bubble_viol, 0);

    // Back-to-back frames.
    send_frame(c_mode_ramp, 1'b0);
    send_frame(c_mode_ramp, 1'b0);
    idle(4);
    check_frames("b2b", c_mode_ramp, 2);

    // Mid-frame reset after 100 pixels; the 100th pixel (row 3, col 21)
    // completes a window, so valid_out is high when rst rises.
    for (int k = 0; k < 100; k++) drive(1'b1, pix(c_mode_ramp, k / W, k % W));
    @(posedge clk);
    #1 valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid_out", valid_out, 0);
    chk("mrst_pixel_out", pixel_out, 0);
    chk("mrst_frame_end", frame_end, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    q_px.delete();
    q_fe.delete();
    send_frame(c_mode_ramp, 1'b0);
    idle(4);
    check_frames("mrst_ramp", c_mode_ramp, 1);

    chk("stray_frame_end", stray_fe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
